// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one M-bit block resolved per stage, valid/ready on both sides.
// Optional build macro PCSA_SAT_EN enables signed saturation of S in the final stage.
module pipelined_csel_adder #(
  parameter int N = 32,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         OF
);

  localparam int L = N / M;

  logic         w_adv;
  logic         w_vld [L];
  logic         w_c   [L];
  logic [N-1:0] w_s   [L];
  logic [N-1:0] w_a   [L];
  logic [N-1:0] w_b   [L];

`ifdef PCSA_SAT_EN
  function automatic logic [N-1:0] sat_fn(input logic [N-1:0] s, input logic of,
                                          input logic sign_a);
    logic signed [N-1:0] lim;
    if (!of) return s;
    lim = sign_a ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return lim;
  endfunction
`endif

  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  // Stage-1 sources come straight from the input port; subtraction folds into B' and c0
  assign w_vld[0] = in_valid;
  assign w_a[0]   = A;
  assign w_b[0]   = sub ? ~B : B;
  assign w_c[0]   = sub | Cin;
  assign w_s[0]   = '0;

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [M:0]   w_sum0;
    logic [M:0]   w_sum1;
    logic [M:0]   w_sel;
    logic [N-1:0] w_snext;

    assign w_sum0 = {1'b0, w_a[k][k*M +: M]} + {1'b0, w_b[k][k*M +: M]};
    assign w_sum1 = {1'b0, w_a[k][k*M +: M]} + {1'b0, w_b[k][k*M +: M]} + {{M{1'b0}}, 1'b1};
    assign w_sel  = w_c[k] ? w_sum1 : w_sum0;

    always_comb begin
      w_snext            = w_s[k];
      w_snext[k*M +: M]  = w_sel[M-1:0];
    end

    if (k < L-1) begin : g_mid
      logic         r_vld;
      logic         r_c;
      logic [N-1:0] r_s;
      logic [N-1:0] r_a;
      logic [N-1:0] r_b;

      // Stage k+1 -> k+2 boundary
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_vld <= 1'b0;
        else if (w_adv) r_vld <= w_vld[k];
      end

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_c <= w_sel[M];
          r_s <= w_snext;
          r_a <= w_a[k];
          r_b <= w_b[k];
        end
      end

      assign w_vld[k+1] = r_vld;
      assign w_c[k+1]   = r_c;
      assign w_s[k+1]   = r_s;
      assign w_a[k+1]   = r_a;
      assign w_b[k+1]   = r_b;
    end else begin : g_last
      logic         w_of;
      logic [N-1:0] w_sres;

      assign w_of = (w_a[k][N-1] == w_b[k][N-1]) && (w_snext[N-1] != w_a[k][N-1]);
`ifdef PCSA_SAT_EN
      assign w_sres = sat_fn(w_snext, w_of, w_a[k][N-1]);
`else
      assign w_sres = w_snext;
`endif

      // Final stage: output register, held while downstream stalls
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          S         <= '0;
          Cout      <= 1'b0;
          OF        <= 1'b0;
        end else if (w_adv) begin
          out_valid <= w_vld[k];
          S         <= w_sres;
          Cout      <= w_sel[M];
          OF        <= w_of;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed bench for pipelined_csel_adder (N=32, M=8): reset, single beats, streaming with stall, mid-stream reset.
module tb_pipelined_csel_adder;
  localparam int N = 32;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, OF;
  logic [N-1:0] A, B, S;

  int n_vec = 0;
  int n_err = 0;

  pipelined_csel_adder #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .OF(OF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide add, returns {OF, Cout, S}
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic ci, input logic sb);
    logic [N-1:0] bb;
    logic [N:0]   t;
    logic [N-1:0] s;
    logic         of;
    bb = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (sb | ci)};
    s  = t[N-1:0];
    of = (a[N-1] == bb[N-1]) && (s[N-1] != a[N-1]);
`ifdef PCSA_SAT_EN
    if (of) s = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    return {of, t[N], s};
  endfunction

  task automatic run_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic ci, input logic sb,
                         input logic [N-1:0] es, input logic ec, input logic eo);
    int cyc;
    A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    #3;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'd4);
    check({tag, "_S"}, 64'(S), 64'(es));
    check({tag, "_Cout"}, 64'(Cout), 64'(ec));
    check({tag, "_OF"}, 64'(OF), 64'(eo));
    tick();
  endtask

  logic [N-1:0] st_a [16];
  logic [N-1:0] st_b [16];
  logic         st_c [16];
  logic         st_s [16];
  logic [N+1:0] q [$];
  logic [N+1:0] e;
  logic [N-1:0] ps;
  logic         pc, po, hs, acc;
  int           idx, got, cyc;

  initial begin
    // Reset held with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; A = '1; B = 32'd1; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_S", 64'(S), 64'd0);
    check("rst_Cout", 64'(Cout), 64'd0);
    check("rst_OF", 64'(OF), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_rdy", 64'(in_ready), 64'd1);

    run_one("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef PCSA_SAT_EN
    run_one("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_one("negovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
    run_one("subovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
    run_one("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("negovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("subovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
    run_one("sub5m7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub7m5", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_one("cin", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_one("subcin", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
    run_one("blocks", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

    // Streaming 16 beats with a 3-cycle downstream stall
    for (int i = 0; i < 16; i++) begin
      st_a[i] = $urandom; st_b[i] = $urandom;
      st_c[i] = 1'($urandom_range(0, 1)); st_s[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; got = 0; cyc = 0;
    A = st_a[0]; B = st_b[0]; Cin = st_c[0]; sub = st_s[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 16 && cyc < 100) begin
      #3;
      if (cyc >= 8 && cyc <= 10) check("stall_rdy", 64'(in_ready), 64'd0);
      hs = out_valid && out_ready; acc = in_valid && in_ready;
      ps = S; pc = Cout; po = OF;
      tick();
      cyc++;
      if (hs) begin
        if (q.size() == 0) check("stream_extra", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          check("stream_S", 64'(ps), 64'(e[N-1:0]));
          check("stream_Cout", 64'(pc), 64'(e[N]));
          check("stream_OF", 64'(po), 64'(e[N+1]));
          got++;
        end
      end
      if (acc) begin
        q.push_back(model(st_a[idx], st_b[idx], st_c[idx], st_s[idx]));
        idx++;
      end
      out_ready = !(cyc >= 8 && cyc <= 10);
      in_valid  = (idx < 16);
      if (idx < 16) begin
        A = st_a[idx]; B = st_b[idx]; Cin = st_c[idx]; sub = st_s[idx];
      end
    end
    check("stream_cnt", 64'(got), 64'd16);
    check("stream_qleft", 64'(q.size()), 64'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    check("stream_dup", 64'(out_valid), 64'd0);

    // Reset while beats are in flight
    A = 32'd1; B = 32'd1; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    check("mid_pre_vld", 64'(out_valid), 64'd1);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("mid_rst_vld", 64'(out_valid), 64'd0);
    check("mid_rst_S", 64'(S), 64'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_stale", 64'(out_valid), 64'd0);
    end
    run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
